fp_multiplication: RTL and testbench

//  - Sequential IEEE-754 single-precision multiplier. It is the inverse-operation companion to fp_division and

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_multiplication_if.sv | 23 ++
 rtl/fp_mant_mul_seq.sv | 53 +++++
 rtl/fp_multiplication.sv | 127 ++++++++++++
 tb/tb_fp_multiplication.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the fp_multiplication / fp_division family.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_multiplication_if.sv
// Operand/result handshake bundle for fp_multiplication.
interface fp_multiplication_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        busy;

  modport master (
    output in_valid, a1, b1, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a1, b1, out_ready,
    output in_ready, out_valid, c, busy
  );

endinterface

// File: rtl/fp_mant_mul_seq.sv
// Iterative unsigned W x W shift-add multiplier, one partial product per cycle.
// done pulses for one cycle after the last partial product has been added.
module fp_mant_mul_seq #(
  parameter int unsigned W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]   a_q;
  logic [2*W-1:0] b_sh;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_sh <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      p    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q  <= a;
        b_sh <= {{W{1'b0}}, b};
        cnt  <= '0;
        run  <= 1'b1;
        p    <= '0;
      end else if (run) begin
        // b_sh always equals b << cnt
        if (a_q[cnt]) begin
          p <= p + b_sh;
        end
        b_sh <= b_sh << 1;
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_multiplication.sv
// Sequential IEEE-754 single-precision multiplier: truncating, denormals flushed to zero.
// Optional FP_MUL_SATURATE_EN: clamp exponent overflow to infinity and underflow to zero.
module fp_multiplication
  import fp_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  fp_multiplication_if.slave bus
);

  localparam int unsigned MW = MANT_W + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_BIAS = XW'(BIAS);

  state_t                 state;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  fp32_t                  c_q;
  logic                   sc_q;
  logic signed [XW-1:0]   exp_q;
  logic                   zero_q;

  fp32_t                  a_f;
  fp32_t                  b_f;
  logic                   fire;
  logic                   mul_done;
  logic [PW-1:0]          prod;

  logic signed [XW-1:0]   exp_inc;
  logic signed [XW-1:0]   exp_n;
  logic [MANT_W-1:0]      mant_n;
  fp32_t                  res_n;

  assign a_f  = bus.a1;
  assign b_f  = bus.b1;
  assign fire = bus.in_valid && in_ready_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.c         = c_q;

  fp_mant_mul_seq #(
    .W(MW)
  ) u_mant_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (fire),
    .a     ({1'b1, a_f.mant}),
    .b     ({1'b1, b_f.mant}),
    .done  (mul_done),
    .p     (prod)
  );

  always_comb begin
    exp_inc    = prod[PW-1] ? XW'(1) : '0;
    exp_n      = exp_q + exp_inc;
    mant_n     = prod[PW-1] ? prod[PW-2 -: MANT_W] : prod[PW-3 -: MANT_W];
    res_n.sign = sc_q;
    res_n.exp  = exp_n[EXP_W-1:0];
    res_n.mant = mant_n;
    if (zero_q) begin
      res_n.exp  = '0;
      res_n.mant = '0;
    end
`ifdef FP_MUL_SATURATE_EN
    else if (exp_n >= EXP_MAX) begin
      res_n.exp  = '1;
      res_n.mant = '0;
    end else if (exp_n <= EXP_ZERO) begin
      res_n.exp  = '0;
      res_n.mant = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      c_q         <= '0;
      sc_q        <= 1'b0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            sc_q       <= a_f.sign ^ b_f.sign;
            exp_q      <= $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp}) - EXP_BIAS;
            zero_q     <= (a_f.exp == '0) || (b_f.exp == '0);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            state <= NORM;
          end
        end
        NORM: begin
          c_q         <= res_n;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          // in_ready reopens only after the result has been taken
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplication.sv
// Directed-vector bench for fp_multiplication (honours FP_MUL_SATURATE_EN if defined).
module tb_fp_multiplication;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fp_multiplication_if bus ();

  fp_multiplication dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Stimulus helper: issue one operand pair, wait for the result, accept it.
  // lat counts rising edges from the acceptance edge until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.a1       = a;
    bus.b1       = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    res = bus.c;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.c !== 32'h0) begin
      errors++; $display("FAIL reset_c: got %h want 00000000", bus.c);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_products();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    logic [31:0] res;
    int lat;
    va[0] = 32'h40000000; vb[0] = 32'h40400000; ve[0] = 32'h40C00000;
    va[1] = 32'h3FC00000; vb[1] = 32'h3FC00000; ve[1] = 32'h40100000;
    va[2] = 32'hC0000000; vb[2] = 32'h3F000000; ve[2] = 32'hBF800000;
    va[3] = 32'h80000000; vb[3] = 32'h40400000; ve[3] = 32'h80000000;
    va[4] = 32'h7F000000; vb[4] = 32'h7F000000;
`ifdef FP_MUL_SATURATE_EN
    ve[4] = 32'h7F800000;
`else
    ve[4] = 32'h3E800000;
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL product_%0d (%h x %h): got %h want %h", i, va[i], vb[i], res, ve[i]);
      end
      checks++;
      if (lat != 26) begin
        errors++; $display("FAIL latency_%0d: got %0d edges want 26", i, lat);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL return_idle_%0d: got in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_hold_and_next();
    logic [31:0] held;
    bit stable;
    bit blocked;
    int lat;
    @(negedge clk);
    bus.a1 = 32'h40000000; bus.b1 = 32'h40400000; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL busy_in_mul: got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); lat++; #1;
    end
    held = bus.c;
    checks++;
    if (held !== 32'h40C00000 || lat != 26) begin
      errors++; $display("FAIL hold_first: got %h after %0d edges want 40C00000 after 26", held, lat);
    end
    @(negedge clk);
    bus.a1 = 32'h3FC00000; bus.b1 = 32'h3FC00000; bus.in_valid = 1'b1;
    stable = 1'b1;
    blocked = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.c !== held || bus.out_valid !== 1'b1) stable = 1'b0;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) blocked = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL hold_stable: got c=%h out_valid=%b want %h/1", bus.c, bus.out_valid, held);
    end
    checks++;
    if (!blocked) begin
      errors++; $display("FAIL hold_blocked: got in_ready=%b busy=%b want 0/0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL accept_next: got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); lat++; #1;
    end
    checks++;
    if (bus.c !== 32'h40100000 || lat != 26) begin
      errors++; $display("FAIL next_result: got %h after %0d edges want 40100000 after 26", bus.c, lat);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    bus.a1 = 32'h40000000; bus.b1 = 32'h40400000; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctrl: got out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
    checks++;
    if (bus.c !== 32'h0) begin
      errors++; $display("FAIL abort_c: got %h want 00000000", bus.c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hC0000000, 32'h3F000000, res, lat);
    checks++;
    if (res !== 32'hBF800000 || lat != 26) begin
      errors++; $display("FAIL after_abort: got %h after %0d edges want BF800000 after 26", res, lat);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bus.in_valid  = 1'b0;
    bus.a1        = '0;
    bus.b1        = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_products();
    test_hold_and_next();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
